// File: rtl/ifetch_pkg.sv
// Shared encodings and constants for the MIPS instruction-fetch sequencer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_INC     = 4;
  localparam logic [31:0] ALIGN_MASK = ~32'd3;

endpackage

// File: rtl/ifetch_pc_ctrl_mux1.sv
// B-bit 2:1 next-PC mux: sel_i=0 passes op0_i (PC+4), sel_i=1 passes op1_i (redirect target).
module Ifetch_mux1 #(
  parameter int B = 32
) (
  input  logic [B-1:0] op0_i,
  input  logic [B-1:0] op1_i,
  input  logic         sel_i,
  output logic [B-1:0] y_o
);

  assign y_o = sel_i ? op1_i : op0_i;

endmodule

// File: rtl/ifetch_pc_ctrl.sv
// IFETCH sequencer: owns the PC, runs the imem req/ready handshake and holds one
// registered instruction for decode, handling stalls and branch/jump redirects.
module ifetch_pc_ctrl
  import ifetch_pkg::*;
#(
  parameter int          B        = 32,
  parameter logic [B-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [B-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [B-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [B-1:0] instr,
  output logic [B-1:0] instr_pc,
  input  logic         id_stall,
  input  logic         br_taken,
  input  logic [B-1:0] br_target,
  input  logic         jump,
  input  logic [B-1:0] jump_target,
  output logic         pc_sel,
  output logic [B-1:0] redir_target
);

  fetch_state_e state_q, state_d;
  logic [B-1:0] pc_q, pc_d;
  logic [B-1:0] pcPending_q, pcPending_d;
  logic [B-1:0] instr_q, instr_d;
  logic [B-1:0] instrPc_q, instrPc_d;
  logic         instrValid_q, instrValid_d;

  logic         redir;
  logic         stallEntry;
  logic [B-1:0] pcPlus4;
  logic [B-1:0] muxOut;

  assign redir        = br_taken | jump;
  assign pc_sel       = redir;
  assign redir_target = (br_taken ? br_target : jump_target) & B'(ALIGN_MASK);
  assign pcPlus4      = pc_q + B'(PC_INC);
  assign stallEntry   = instrValid_q & id_stall;

  Ifetch_mux1 #(.B(B)) uNextPcMux (
    .op0_i (pcPlus4),
    .op1_i (redir_target),
    .sel_i (pc_sel),
    .y_o   (muxOut)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      pcPending_q  <= '0;
      instr_q      <= '0;
      instrPc_q    <= '0;
      instrValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pcPending_q  <= pcPending_d;
      instr_q      <= instr_d;
      instrPc_q    <= instrPc_d;
      instrValid_q <= instrValid_d;
    end
  end

  // Output entry drains when decode consumes it; capture below refills it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pcPending_d  = pcPending_q;
    instr_d      = instr_q;
    instrPc_d    = instrPc_q;
    instrValid_d = instrValid_q & id_stall;
    imem_req     = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redir) pc_d = muxOut;
      end
      FETCH: begin
        if (stallEntry) begin
          if (redir) pc_d = muxOut;
          else       state_d = HOLD;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            pc_d = muxOut;
            if (!redir) begin
              instr_d      = imem_rdata;
              instrPc_d    = pc_q;
              instrValid_d = 1'b1;
            end
          end else if (redir) begin
            pcPending_d = redir_target;
            state_d     = KILL;
          end
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d    = muxOut;
          state_d = FETCH;
        end else if (!id_stall) begin
          state_d = FETCH;
        end
      end
      KILL: begin
        imem_req = 1'b1;
        if (redir) pcPending_d = redir_target;
        if (imem_ready) begin
          pc_d    = redir ? muxOut : pcPending_q;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase

    if (redir) instrValid_d = 1'b0;
  end

  assign imem_addr   = pc_q;
  assign instr_valid = instrValid_q;
  assign instr       = instr_q;
  assign instr_pc    = instrPc_q;

endmodule

// File: tb/tb_ifetch_pc_ctrl.sv
// Directed, table-driven bench for ifetch_pc_ctrl plus a wrap-around instance.
module tb_ifetch_pc_ctrl;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        stall;
    logic        br;
    logic [31:0] brT;
    logic        jmp;
    logic [31:0] jmpT;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eInstr;
    logic [31:0] ePc;
    logic        ePcSel;
    logic [31:0] eRedir;
  } vecT;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic        idStall;
  logic        brTaken;
  logic [31:0] brTarget;
  logic        jumpIn;
  logic [31:0] jumpTarget;

  logic        imemReq, instrValid, pcSel;
  logic [31:0] imemAddr, instrOut, instrPc, redirTarget;
  logic        wReq, wValid, wPcSel;
  logic [31:0] wAddr, wInstr, wInstrPc, wRedir;

  int assertCount = 0;
  int failCount   = 0;
  vecT vecs[24];

  always #5 clk = ~clk;

  ifetch_pc_ctrl #(.B(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_ready(imemReady), .imem_rdata(imemRdata), .instr_valid(instrValid),
    .instr(instrOut), .instr_pc(instrPc), .id_stall(idStall), .br_taken(brTaken),
    .br_target(brTarget), .jump(jumpIn), .jump_target(jumpTarget),
    .pc_sel(pcSel), .redir_target(redirTarget)
  );

  ifetch_pc_ctrl #(.B(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .reset(reset), .imem_req(wReq), .imem_addr(wAddr),
    .imem_ready(imemReady), .imem_rdata(imemRdata), .instr_valid(wValid),
    .instr(wInstr), .instr_pc(wInstrPc), .id_stall(idStall), .br_taken(brTaken),
    .br_target(brTarget), .jump(jumpIn), .jump_target(jumpTarget),
    .pc_sel(wPcSel), .redir_target(wRedir)
  );

  function automatic vecT mk(input logic rst, input logic rdy, input logic [31:0] rdata,
                             input logic stall, input logic br, input logic [31:0] brT,
                             input logic jmp, input logic [31:0] jmpT,
                             input logic eReq, input logic [31:0] eAddr, input logic eValid,
                             input logic [31:0] eInstr, input logic [31:0] ePc,
                             input logic ePcSel, input logic [31:0] eRedir);
    vecT v;
    v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.stall = stall;
    v.br = br; v.brT = brT; v.jmp = jmp; v.jmpT = jmpT;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr;
    v.ePc = ePc; v.ePcSel = ePcSel; v.eRedir = eRedir;
    return v;
  endfunction

  task automatic applyStimulus(input vecT v);
    reset      = v.rst;
    imemReady  = v.rdy;
    imemRdata  = v.rdata;
    idStall    = v.stall;
    brTaken    = v.br;
    brTarget   = v.brT;
    jumpIn     = v.jmp;
    jumpTarget = v.jmpT;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkVec(input string tag, input vecT v);
    checkOutput({tag, " imem_req"},     {31'd0, imemReq},    {31'd0, v.eReq});
    checkOutput({tag, " imem_addr"},    imemAddr,            v.eAddr);
    checkOutput({tag, " instr_valid"},  {31'd0, instrValid}, {31'd0, v.eValid});
    checkOutput({tag, " instr"},        instrOut,            v.eInstr);
    checkOutput({tag, " instr_pc"},     instrPc,             v.ePc);
    checkOutput({tag, " pc_sel"},       {31'd0, pcSel},      {31'd0, v.ePcSel});
    checkOutput({tag, " redir_target"}, redirTarget,         v.eRedir);
  endtask

  initial begin
    vecT h;
    // rst rdy rdata stall br brT jmp jmpT | req addr valid instr pc sel redir
    vecs[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h000, 0, 32'h0,         32'h000, 0, 32'h0);
    vecs[1]  = mk(0, 1, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h000, 0, 32'h0,         32'h000, 0, 32'h0);
    vecs[2]  = mk(0, 1, 32'h1111_0000, 0, 0, 32'h0,   0, 32'h0,   1, 32'h000, 0, 32'h0,         32'h000, 0, 32'h0);
    vecs[3]  = mk(0, 1, 32'h1111_0004, 0, 0, 32'h0,   0, 32'h0,   1, 32'h004, 1, 32'h1111_0000, 32'h000, 0, 32'h0);
    vecs[4]  = mk(0, 1, 32'h1111_0008, 0, 0, 32'h0,   0, 32'h0,   1, 32'h008, 1, 32'h1111_0004, 32'h004, 0, 32'h0);
    vecs[5]  = mk(0, 1, 32'h1111_000C, 1, 0, 32'h0,   0, 32'h0,   0, 32'h00C, 1, 32'h1111_0008, 32'h008, 0, 32'h0);
    vecs[6]  = mk(0, 1, 32'h1111_000C, 1, 0, 32'h0,   0, 32'h0,   0, 32'h00C, 1, 32'h1111_0008, 32'h008, 0, 32'h0);
    vecs[7]  = mk(0, 1, 32'h1111_000C, 1, 0, 32'h0,   0, 32'h0,   0, 32'h00C, 1, 32'h1111_0008, 32'h008, 0, 32'h0);
    vecs[8]  = mk(0, 1, 32'h1111_000C, 0, 0, 32'h0,   0, 32'h0,   0, 32'h00C, 1, 32'h1111_0008, 32'h008, 0, 32'h0);
    vecs[9]  = mk(0, 1, 32'h1111_000C, 0, 0, 32'h0,   0, 32'h0,   1, 32'h00C, 0, 32'h1111_0008, 32'h008, 0, 32'h0);
    vecs[10] = mk(0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   1, 32'h010, 1, 32'h1111_000C, 32'h00C, 0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,         0, 1, 32'h203, 0, 32'h0,   1, 32'h010, 0, 32'h1111_000C, 32'h00C, 1, 32'h200);
    vecs[12] = mk(0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   1, 32'h010, 0, 32'h1111_000C, 32'h00C, 0, 32'h0);
    vecs[13] = mk(0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   1, 32'h010, 0, 32'h1111_000C, 32'h00C, 0, 32'h0);
    vecs[14] = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,   0, 32'h0,   1, 32'h010, 0, 32'h1111_000C, 32'h00C, 0, 32'h0);
    vecs[15] = mk(0, 1, 32'h2222_0200, 0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h1111_000C, 32'h00C, 0, 32'h0);
    vecs[16] = mk(0, 1, 32'hBAD0_0204, 0, 1, 32'h100, 1, 32'h300, 1, 32'h204, 1, 32'h2222_0200, 32'h200, 1, 32'h100);
    vecs[17] = mk(0, 1, 32'h3333_0100, 0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h2222_0200, 32'h200, 0, 32'h0);
    vecs[18] = mk(0, 1, 32'h3333_0104, 0, 0, 32'h0,   0, 32'h0,   1, 32'h104, 1, 32'h3333_0100, 32'h100, 0, 32'h0);
    vecs[19] = mk(0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   1, 32'h108, 1, 32'h3333_0104, 32'h104, 0, 32'h0);
    vecs[20] = mk(0, 0, 32'h0,         0, 0, 32'h0,   1, 32'h402, 1, 32'h108, 0, 32'h3333_0104, 32'h104, 1, 32'h400);
    vecs[21] = mk(0, 0, 32'h0,         0, 1, 32'h500, 0, 32'h0,   1, 32'h108, 0, 32'h3333_0104, 32'h104, 1, 32'h500);
    vecs[22] = mk(0, 1, 32'h5555_5555, 0, 0, 32'h0,   0, 32'h0,   1, 32'h108, 0, 32'h3333_0104, 32'h104, 0, 32'h0);
    vecs[23] = mk(0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   1, 32'h500, 0, 32'h3333_0104, 32'h104, 0, 32'h0);

    applyStimulus(vecs[0]);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      #1 applyStimulus(vecs[i]);
      #1 checkVec($sformatf("row%0d", i), vecs[i]);
      if (i == 2) checkOutput("wrap addr top", wAddr, 32'hFFFF_FFFC);
      if (i == 3) checkOutput("wrap addr zero", wAddr, 32'h0000_0000);
      @(posedge clk);
    end

    // Redirect while stalled on memory, then reset in the middle of KILL.
    #1 applyStimulus(mk(0, 0, 32'h0, 0, 1, 32'h600, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("kill entry req", {31'd0, imemReq}, 32'd1);
    checkOutput("kill entry addr", imemAddr, 32'h500);
    @(posedge clk);
    #1 applyStimulus(mk(1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("kill hold req", {31'd0, imemReq}, 32'd1);
    checkOutput("kill hold addr", imemAddr, 32'h500);
    @(posedge clk);

    // After reset: BOOT with a jump loads the target for the first fetch.
    h = mk(0, 1, 32'h0, 0, 0, 32'h0, 1, 32'h41, 0, 32'h0, 0, 32'h0, 32'h0, 1, 32'h40);
    #1 applyStimulus(h);
    #1 checkVec("post-reset boot", h);
    checkOutput("wrap post-reset addr", wAddr, 32'hFFFF_FFFC);
    checkOutput("wrap post-reset req", {31'd0, wReq}, 32'd0);
    @(posedge clk);
    h = mk(0, 1, 32'h4444_0040, 0, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0, 32'h0, 32'h0, 0, 32'h0);
    #1 applyStimulus(h);
    #1 checkVec("boot jump fetch", h);
    @(posedge clk);
    h = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h44, 1, 32'h4444_0040, 32'h40, 0, 32'h0);
    #1 applyStimulus(h);
    #1 checkVec("boot jump capture", h);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
